reel_spinner: RTL and testbench



---
 rtl/reel_spinner_pkg.sv | 32 +++
 rtl/reel_spinner_lfsr16.sv | 23 ++
 rtl/reel_spinner.sv | 114 +++++++++++
 tb/tb_reel_spinner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reel_spinner_pkg.sv
// Shared definitions for the reel spinner and its neighbours.
//   - Symbol codes driven on each 3-bit reel field (BLANK = 0 plus seven symbols).
//   - FSM state encodings for the spinner.
//   - Galois LFSR feedback mask and single-step helper.
package reel_spinner_pkg;

    // Symbol codes consumed by the payout lookup
    localparam logic [2:0] SYM_BLANK   = 3'd0;
    localparam logic [2:0] SYM_CHERRY  = 3'd1;
    localparam logic [2:0] SYM_LEMON   = 3'd2;
    localparam logic [2:0] SYM_ORANGE  = 3'd3;
    localparam logic [2:0] SYM_PLUM    = 3'd4;
    localparam logic [2:0] SYM_BELL    = 3'd5;
    localparam logic [2:0] SYM_BAR     = 3'd6;
    localparam logic [2:0] SYM_SEVEN   = 3'd7;

    // Spinner FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SPIN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 16-bit Galois LFSR feedback mask (maximal length, never reaches zero
    // from a nonzero seed)
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = {1'b0, cur[15:1]};
        return cur[0] ? (shifted ^ LFSR_MASK) : shifted;
    endfunction

endpackage

// File: rtl/reel_spinner_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, advances every clock.
//   clk   - system clock
//   reset - synchronous active-high, loads SEED
//   q     - current LFSR state
module lfsr16
    import reel_spinner_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/reel_spinner.sv
// reel_spinner: three-reel slot spinner.
// A spin request in IDLE loads a random step count per reel; all reels then
// advance together once every STEP_CYCLES clocks and stop in order
// reel0, reel1, reel2. A one-cycle done pulse marks final symbols.
//   clk         - system clock
//   reset       - synchronous active-high reset, aborts any spin
//   spin_req    - spin request, sampled only in IDLE
//   symbols     - {reel2, reel1, reel0} 3-bit symbol codes
//   reel_moving - bit i high while reel i has steps remaining
//   busy        - high while spinning
//   done        - one-cycle pulse, symbols are final
module reel_spinner
    import reel_spinner_pkg::*;
#(
    parameter int          STEP_CYCLES   = 4,
    parameter int          MIN_STEPS     = 24,
    parameter int          STAGGER_STEPS = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spin_req,
    output logic [8:0] symbols,
    output logic [2:0] reel_moving,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(STEP_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);

    localparam logic [7:0] BASE0 = 8'(MIN_STEPS);
    localparam logic [7:0] BASE1 = 8'(MIN_STEPS + STAGGER_STEPS);
    localparam logic [7:0] BASE2 = 8'(MIN_STEPS + 2 * STAGGER_STEPS);

    logic [1:0]      state;
    logic [PW-1:0]   presc;
    logic [2:0][7:0] rem;
    logic [2:0][2:0] sym;
    logic [15:0]     lfsr;
    logic            tick;

    // Only the low nine LFSR bits pick stop offsets
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr[15:9];

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign tick    = (presc == PRESC_LAST);
    assign symbols = sym;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            presc       <= '0;
            rem         <= '0;
            sym         <= '0;
            reel_moving <= 3'b000;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (spin_req) begin
                        // Later reels get a larger base so the stop order is strict
                        rem[0]      <= BASE0 + {5'd0, lfsr[2:0]};
                        rem[1]      <= BASE1 + {5'd0, lfsr[5:3]};
                        rem[2]      <= BASE2 + {5'd0, lfsr[8:6]};
                        presc       <= '0;
                        state       <= ST_SPIN;
                        busy        <= 1'b1;
                        reel_moving <= 3'b111;
                    end
                end
                ST_SPIN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        for (int i = 0; i < 3; i++) begin
                            if (rem[i] != 8'd0) begin
                                sym[i] <= sym[i] + 3'd1;
                                rem[i] <= rem[i] - 8'd1;
                            end
                            // Moving after this tick only if more than one step was left
                            reel_moving[i] <= (rem[i] > 8'd1);
                        end
                        // reel2 always stops last, so its final step ends the spin
                        if (rem[2] == 8'd1) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reel_spinner.sv
module tb_reel_spinner;

    localparam int          S    = 4;
    localparam int          MIN  = 24;
    localparam int          STG  = 8;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] MASK = 16'hB400;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spin_req = 1'b0;
    logic [8:0] symbols;
    logic [2:0] reel_moving;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reel_spinner #(
        .STEP_CYCLES   (S),
        .MIN_STEPS     (MIN),
        .STAGGER_STEPS (STG),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spin_req    (spin_req),
        .symbols     (symbols),
        .reel_moving (reel_moving),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- reference model (event/time based) ----------------
    int          e = 0;          // posedge count
    int          m_acc_e = 0;    // edge at which current spin was accepted
    bit          m_active = 1'b0;
    int          m_rem[3];
    int          m_base[3];
    logic [15:0] m_lfsr;
    logic [8:0]  ex_sym;
    logic [2:0]  ex_mv;
    logic        ex_busy, ex_done;
    int          dn_cnt = 0;

    function automatic logic [15:0] ref_step(input logic [15:0] x);
        if (x[0]) return (x >> 1) ^ MASK;
        return x >> 1;
    endfunction

    always @(posedge clk) begin
        int t, steps;
        e++;
        if (reset) begin
            m_lfsr   = SEED;
            m_active = 1'b0;
            for (int i = 0; i < 3; i++) m_base[i] = 0;
        end else begin
            // spin fully retired (DONE cycle over): final positions become new start
            if (m_active && (e - m_acc_e) >= m_rem[2] * S + 2) begin
                for (int i = 0; i < 3; i++) m_base[i] = (m_base[i] + m_rem[i]) % 8;
                m_active = 1'b0;
            end
            if (!m_active && spin_req) begin
                m_acc_e  = e;
                m_active = 1'b1;
                m_rem[0] = MIN + int'(m_lfsr[2:0]);
                m_rem[1] = MIN + STG + int'(m_lfsr[5:3]);
                m_rem[2] = MIN + 2 * STG + int'(m_lfsr[8:6]);
            end
            m_lfsr = ref_step(m_lfsr);
        end
        if (!m_active) begin
            for (int i = 0; i < 3; i++) ex_sym[3*i +: 3] = 3'(m_base[i]);
            ex_mv   = 3'b000;
            ex_busy = 1'b0;
            ex_done = 1'b0;
        end else begin
            t = e - m_acc_e;
            for (int i = 0; i < 3; i++) begin
                steps = (t / S < m_rem[i]) ? t / S : m_rem[i];
                ex_sym[3*i +: 3] = 3'((m_base[i] + steps) % 8);
                ex_mv[i] = (t < m_rem[i] * S);
            end
            ex_busy = (t < m_rem[2] * S);
            ex_done = (t == m_rem[2] * S);
        end
    end

    always @(negedge clk) begin
        if (e > 0) begin
            checks++;
            if ({symbols, reel_moving, busy, done} !== {ex_sym, ex_mv, ex_busy, ex_done}) begin
                failures++;
                $display("FAIL model_cycle%0d got sym=%o mv=%b busy=%b done=%b want sym=%o mv=%b busy=%b done=%b",
                         e, symbols, reel_moving, busy, done, ex_sym, ex_mv, ex_busy, ex_done);
            end
            checks++;
            if (dut.u_lfsr.q !== m_lfsr) begin
                failures++;
                $display("FAIL lfsr_cycle%0d got %h want %h", e, dut.u_lfsr.q, m_lfsr);
            end
            if (done === 1'b1) dn_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        bit         rst;
        bit         req;
        int         n;
        logic [8:0] sym;
        logic [2:0] mv;
        bit         bsy;
        bit         dn;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit ok, ok2;
        int d1, d2, cnt0, lat;

        tbl[0] = '{1'b1, 1'b0, 3, 9'h000, 3'b000, 1'b0, 1'b0}; // reset held
        tbl[1] = '{1'b1, 1'b1, 1, 9'h000, 3'b000, 1'b0, 1'b0}; // reset beats request
        tbl[2] = '{1'b0, 1'b0, 2, 9'h000, 3'b000, 1'b0, 1'b0}; // idle
        tbl[3] = '{1'b0, 1'b1, 1, 9'h000, 3'b111, 1'b1, 1'b0}; // accepted, no tick yet
        tbl[4] = '{1'b0, 1'b1, 2, 9'h000, 3'b111, 1'b1, 1'b0}; // request ignored in SPIN
        tbl[5] = '{1'b0, 1'b0, 2, 9'h049, 3'b111, 1'b1, 1'b0}; // first tick: each reel 0->1
        tbl[6] = '{1'b1, 1'b0, 1, 9'h000, 3'b000, 1'b0, 1'b0}; // reset mid-spin
        tbl[7] = '{1'b0, 1'b0, 3, 9'h000, 3'b000, 1'b0, 1'b0}; // stays idle

        for (int i = 0; i < 8; i++) begin
            reset    = tbl[i].rst;
            spin_req = tbl[i].req;
            repeat (tbl[i].n) @(posedge clk);
            @(negedge clk);
            checks++;
            if ({symbols, reel_moving, busy, done} !== {tbl[i].sym, tbl[i].mv, tbl[i].bsy, tbl[i].dn}) begin
                failures++;
                $display("FAIL vec%0d got sym=%o mv=%b busy=%b done=%b want sym=%o mv=%b busy=%b done=%b",
                         i, symbols, reel_moving, busy, done, tbl[i].sym, tbl[i].mv, tbl[i].bsy, tbl[i].dn);
            end
        end
        spin_req = 1'b0;

        // Single spin with ignored requests at cycles ~10 and ~100
        cnt0 = dn_cnt;
        spin_req = 1'b1;
        @(negedge clk);
        spin_req = 1'b0;
        repeat (9) @(negedge clk);
        spin_req = 1'b1;
        @(negedge clk);
        spin_req = 1'b0;
        repeat (89) @(negedge clk);
        spin_req = 1'b1;
        @(negedge clk);
        spin_req = 1'b0;
        wait_done(400, ok);
        check("single_done_seen", int'(ok), 1);
        lat = e - m_acc_e;
        check("single_latency", lat, m_rem[2] * S);
        check("single_rem2_range", int'(m_rem[2] >= MIN + 2 * STG && m_rem[2] <= MIN + 2 * STG + 7), 1);
        repeat (4) @(negedge clk);
        check("single_done_once", dn_cnt - cnt0, 1);
        check("single_idle_busy", int'(busy), 0);

        // Held request: back-to-back spins, second accepted in IDLE after done
        spin_req = 1'b1;
        wait_done(400, ok);
        d1 = e;
        wait_done(400, ok2);
        d2 = e;
        spin_req = 1'b0;
        check("held_first_done", int'(ok), 1);
        check("held_second_done", int'(ok2), 1);
        check("held_gap", d2 - d1, 2 + m_rem[2] * S);

        // Reset at roughly step 30 of a spin
        repeat (3) @(negedge clk);
        spin_req = 1'b1;
        @(negedge clk);
        spin_req = 1'b0;
        repeat (30 * S - 1) @(negedge clk);
        check("midspin_busy_before", int'(busy), 1);
        cnt0 = dn_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midspin_cleared", int'({symbols, reel_moving, busy, done}), 0);
        repeat (60) @(negedge clk);
        check("midspin_no_done", dn_cnt - cnt0, 0);
        spin_req = 1'b1;
        @(negedge clk);
        spin_req = 1'b0;
        wait_done(400, ok);
        check("after_reset_done", int'(ok), 1);

        // Randomised traffic: request noise in every state, occasional reset
        cnt0 = dn_cnt;
        for (int c = 0; c < 6000; c++) begin
            spin_req = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        spin_req = 1'b0;
        check("random_enough_spins", int'((dn_cnt - cnt0) >= 5), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
